// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one external combinational ALU through an issue/result pipeline.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_o
);

  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic             s1_valid_r;
  logic             s1_owner_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [3:0]       s1_sel_r;
  logic             s2_v0_r;
  logic             s2_v1_r;
  logic [WIDTH-1:0] s2_data_r;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Grant selection: port 0 always wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst || flush) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else begin
      grant1_s = req1_valid;
    end
  end
`else
  logic ptr_r;

  // Grant selection: ptr_r holds the last-granted port, so the other one wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst || flush) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0_s = ptr_r;
      grant1_s = ~ptr_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // Round-robin pointer; moves only on an actual handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b1;
    end else if (grant0_s || grant1_s) begin
      ptr_r <= grant1_s;
    end
  end
`endif

  assign accept_s   = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Issue stage: operand registers keep their last value when idle so the ALU inputs stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_owner_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_sel_r   <= 4'b0000;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_owner_r <= grant1_s;
        s1_a_r     <= grant1_s ? req1_a   : req0_a;
        s1_b_r     <= grant1_s ? req1_b   : req0_b;
        s1_sel_r   <= grant1_s ? req1_sel : req0_sel;
      end
    end
  end

  assign alu_a   = s1_a_r;
  assign alu_b   = s1_b_r;
  assign alu_sel = s1_sel_r;

  // Result stage: per-port strobes are registered directly so the outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v0_r   <= 1'b0;
      s2_v1_r   <= 1'b0;
      s2_data_r <= {WIDTH{1'b0}};
    end else if (flush) begin
      s2_v0_r <= 1'b0;
      s2_v1_r <= 1'b0;
    end else begin
      s2_v0_r <= s1_valid_r & ~s1_owner_r;
      s2_v1_r <= s1_valid_r & s1_owner_r;
      if (s1_valid_r) begin
        s2_data_r <= alu_o;
      end
    end
  end

  assign rsp0_valid = s2_v0_r;
  assign rsp1_valid = s2_v1_r;
  assign rsp_data   = s2_data_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU model, grant predictor and a due-cycle scoreboard.
module tb_alu_arbiter;
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b0011;
  localparam logic [3:0] XOR  = 4'b0100;
  localparam logic [3:0] SUB  = 4'b1100;
  localparam logic [3:0] SRA  = 4'b1101;

  logic        clk = 1'b1;
  logic        rst, flush;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data, alu_a, alu_b, alu_o;
  logic [3:0]  alu_sel;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   tb_ptr = 1'b1;
  logic exp_r0, exp_r1;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_o(alu_o)
  );

  // Shared ALU model (ALUSel encoding).
  always_comb begin
    case (alu_sel)
      4'd0:    alu_o = alu_a + alu_b;
      4'd1:    alu_o = alu_a << alu_b[4:0];
      4'd2:    alu_o = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd3:    alu_o = {31'd0, alu_a < alu_b};
      4'd4:    alu_o = alu_a ^ alu_b;
      4'd5:    alu_o = alu_a >> alu_b[4:0];
      4'd6:    alu_o = alu_a | alu_b;
      4'd7:    alu_o = alu_a & alu_b;
      4'd12:   alu_o = alu_a - alu_b;
      4'd13:   alu_o = $signed(alu_a) >>> alu_b[4:0];
      default: alu_o = alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus, predict the grant and queue the expected response.
  task automatic op(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                    input logic [3:0] s0, input logic [31:0] r0,
                    input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                    input logic [3:0] s1, input logic [31:0] r1, input logic fl);
    bit g0, g1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    flush = fl;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !fl) begin
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g0 = 1'b1;
`else
        g0 = tb_ptr;
        g1 = !tb_ptr;
`endif
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    exp_r0 = g0;
    exp_r1 = g1;
    if (g0) begin
      sb.push_back('{due: cyc + 2, port: 1'b0, data: r0});
      tb_ptr = 1'b0;
    end
    if (g1) begin
      sb.push_back('{due: cyc + 2, port: 1'b1, data: r1});
      tb_ptr = 1'b1;
    end
    if (rst || fl) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due > cyc) sb.delete(i);
      end
    end
    if (rst) tb_ptr = 1'b1;
    tick();
  endtask

  task automatic idle();
    op(1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
  endtask

  // Mid-cycle monitor: readies against prediction, strobes against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("req0_ready", req0_ready, exp_r0);
    chk("req1_ready", req1_ready, exp_r1);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp0_valid", rsp0_valid, !e.port);
      chk("rsp1_valid", rsp1_valid, e.port);
      chk("rsp_data", rsp_data, e.data);
    end else begin
      chk("rsp0_idle", rsp0_valid, 1'b0);
      chk("rsp1_idle", rsp1_valid, 1'b0);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    // Readies must stay low under reset even with both ports requesting.
    op(1'b1, 32'd1, 32'd1, ADD, 32'd0, 1'b1, 32'd1, 32'd1, ADD, 32'd0, 1'b0);
    op(1'b1, 32'd1, 32'd1, ADD, 32'd0, 1'b1, 32'd1, 32'd1, ADD, 32'd0, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;

    // ADD on port 0, then hold of ALU operands while idle.
    op(1'b1, 32'd5, 32'd3, ADD, 32'd8, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
    chk("issue_alu_a", alu_a, 32'd5);
    chk("issue_alu_b", alu_b, 32'd3);
    idle(); idle(); idle();
    chk("hold_alu_a", alu_a, 32'd5);
    chk("hold_alu_sel", {28'd0, alu_sel}, {28'd0, ADD});

    // SRA on port 1 alone, then SLT/SLTU back to back on port 0.
    op(1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b1, 32'h8000_0000, 32'd4, SRA, 32'hF800_0000, 1'b0);
    op(1'b1, 32'hFFFF_FFFF, 32'd1, SLT, 32'd1, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
    op(1'b1, 32'hFFFF_FFFF, 32'd1, SLTU, 32'd0, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
    idle(); idle();

    // Both ports requesting continuously after reset.
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      op(1'b1, 32'h10, 32'h1, SUB, 32'hF, 1'b1, 32'hF0, 32'hFF, XOR, 32'h0F, 1'b0);
    idle(); idle();

    // Accept two ops, flush in the third cycle with both ports still requesting.
    op(1'b1, 32'd1, 32'd2, ADD, 32'd3, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
    op(1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b1, 32'd10, 32'd20, ADD, 32'd30, 1'b0);
    op(1'b1, 32'd7, 32'd7, ADD, 32'd14, 1'b1, 32'd9, 32'd9, ADD, 32'd18, 1'b1);
    idle();
    // Pointer untouched by flush: tie resolves from the last real grant.
    op(1'b1, 32'd4, 32'd4, ADD, 32'd8, 1'b1, 32'd6, 32'd6, ADD, 32'd12, 1'b0);
    idle(); idle();

    // Accept port 0, reset next cycle: no response, then port 0 wins the tie.
    op(1'b1, 32'd2, 32'd2, ADD, 32'd4, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
    op(1'b1, 32'd2, 32'd2, ADD, 32'd4, 1'b0, 32'd0, 32'd0, ADD, 32'd0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    op(1'b1, 32'd11, 32'd1, SUB, 32'd10, 1'b1, 32'd3, 32'd5, XOR, 32'd6, 1'b0);
    idle(); idle(); idle();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The clk port SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The rst port SHALL be an input, 1 bit wide, and is the reset: synchronous and active-high.
REQ-004 The flush port SHALL be an input, 1 bit wide, and discards all in-flight operations.
REQ-005 The req0_valid and req1_valid ports SHALL be inputs, 1 bit wide each, and signal a request present on port 0 and port 1.
REQ-006 The req0_ready and req1_ready ports SHALL be outputs, 1 bit wide each, and signal a request accepted this cycle.
REQ-007 The req0_a, req0_b, req1_a and req1_b ports SHALL be inputs, 32 bits wide each, and carry the operands.
REQ-008 The req0_sel and req1_sel ports SHALL be inputs, 4 bits wide each, and carry the ALU operation in ALUSel encoding.
REQ-009 The rsp0_valid and rsp1_valid ports SHALL be outputs, 1 bit wide each, and are one-cycle result strobes with no backpressure.
REQ-010 The rsp_data port SHALL be an output, 32 bits wide, and carries the result; it is valid while either rsp strobe is high.
REQ-011 The alu_a and alu_b ports SHALL be outputs, 32 bits wide each, and drive the operands to the shared ALU.
REQ-012 The alu_sel port SHALL be an output, 4 bits wide, and drives ALUSel to the shared ALU.
REQ-013 The alu_o port SHALL be an input, 32 bits wide, and carries the combinational result from the shared ALU.

Function
REQ-014 Arbitration SHALL be combinational: at most one reqN_ready high per cycle, and only when reqN_valid is high and flush/rst are low.
REQ-015 A handshake SHALL be reqN_valid & reqN_ready at a rising edge; one acceptance is possible per cycle (full throughput).
REQ-016 Stage 1 (issue) registers SHALL hold a, b, sel, owner ID and a valid bit, and drive alu_a/alu_b/alu_sel directly from these registers.
REQ-017 Stage 2 (result) registers SHALL capture alu_o, owner and valid at the edge after issue.
REQ-018 The rspN_valid of the owner SHALL be high exactly one cycle: a request accepted in cycle 0 responds in cycle 2.
REQ-019 When stage 1 is invalid, alu_a/alu_b/alu_sel SHALL hold their last values (no toggling).
REQ-020 Under round-robin, a pointer SHALL hold the last-granted port; with both valid, the other port wins; the pointer updates only on a handshake.
REQ-021 With a single requester valid, that requester SHALL be granted regardless of the pointer.
REQ-022 Responses SHALL return in acceptance order; back-to-back grants alternating 0,1,0 produce strobes 0,1,0 on consecutive cycles.
REQ-023 On flush high, both stage valids SHALL clear at that edge, no request is accepted that cycle, pending strobes are suppressed, and the pointer is unchanged.
REQ-024 Simultaneous flush and a strobe already high in the same cycle SHALL still complete that strobe (it is an output of stage 2).

Reset
REQ-025 On rst high at a rising edge, stage valids, rspN_valid, req readies (combinationally) and all data registers SHALL be 0, and the pointer SHALL be set to 1 so port 0 wins first.
REQ-026 Reset asserted mid-operation SHALL drop in-flight operations with no response; the first acceptance is possible in the cycle after rst deasserts.

Configuration
REQ-027 The macro ALU_ARB_FIXED_PRIO_EN SHALL select fixed priority when defined: port 0 always wins ties and the pointer logic is removed.
REQ-028 When ALU_ARB_FIXED_PRIO_EN is undefined, the block SHALL use the round-robin arbitration of REQ-020; all other behaviour is identical.

Verification
REQ-029 Port 0 only, a=5, b=3, sel=0000 (ADD) in cycle 0 -> alu_a=5 in cycle 1; rsp0_valid=1 and rsp_data=8 in cycle 2 only.
REQ-030 Both ports valid continuously after reset, port 0 SUB 0x10-1, port 1 XOR 0xF0^0xFF -> grants 0,1,0,1; rsp_data 0xF, 0x0F alternating from cycle 2 (fixed-prio build: port 0 every cycle).
REQ-031 Port 1 SRA a=0x80000000, b=4, sel=1101 -> rsp1_valid with rsp_data=0xF8000000, two cycles later.
REQ-032 Accept in cycles 0 and 1, flush in cycle 2 -> the cycle-2 strobe for the op from cycle 0 is seen, the op from cycle 1 gets no strobe, and neither ready is asserted in cycle 2.
REQ-033 rst in cycle 1 after an acceptance in cycle 0 -> no rsp strobe; the next request with both valid is granted port 0.
REQ-034 SLT a=-1, b=1, sel=0010 -> rsp_data=1; SLTU sel=0011 with the same operands -> rsp_data=0.
